// File: rtl/wb_route_pkg.sv
// wb_route_pkg: shared FSM state encoding and destination-select constants
// for the write-back router. The choice constants match the operand-source
// mux encoding so both blocks agree on what choice=1 means.
package wb_route_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AC_WR   = 2'd1,
    MEM_REQ = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic CHOICE_AC  = 1'b1;
  localparam logic CHOICE_MEM = 1'b0;

endpackage

// File: rtl/wb_route_if.sv
// wb_route_if: write-back request, accumulator and memory-write signals.
//   master: request source / memory model side (drives wr_valid, data_in,
//           addr_in, choice, mem_ack)
//   slave : wb_route side (drives wr_ready, ac_out, ac_we, mem_req,
//           mem_addr, mem_data, err)
interface wb_route_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr_in;
  logic              choice;
  logic [DATA_W-1:0] ac_out;
  logic              ac_we;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;
  logic              err;

  modport master (
    output wr_valid, data_in, addr_in, choice, mem_ack,
    input  wr_ready, ac_out, ac_we, mem_req, mem_addr, mem_data, err
  );

  modport slave (
    input  wr_valid, data_in, addr_in, choice, mem_ack,
    output wr_ready, ac_out, ac_we, mem_req, mem_addr, mem_data, err
  );

endinterface

// File: rtl/wb_timer.sv
// wb_timer: saturating wait counter for memory-write acknowledge timeout.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (takes priority over enable)
//   enable     : count this cycle (saturates at LIMIT, never wraps)
//   done_c     : combinational; this enabled cycle brings the count to LIMIT
module wb_timer #(
  parameter int unsigned LIMIT = 15,
  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done_c
);

  logic [CNT_W-1:0] count;

  // Counter register with saturation at LIMIT
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count < CNT_W'(LIMIT))) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flags the increment that makes the count reach LIMIT
  assign done_c = enable && ((32'(count) + 32'd1) >= LIMIT);

endmodule

// File: rtl/wb_route.sv
// wb_route: routes a write-back result either into the accumulator or out as
// a memory write with acknowledge timeout.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_route_if.slave -- request handshake (wr_valid/wr_ready,
//                data_in, addr_in, choice), accumulator (ac_out, ac_we),
//                memory write (mem_req, mem_addr, mem_data, mem_ack), err
module wb_route
  import wb_route_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  wb_route_if.slave   bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              wr_ready_q, wr_ready_d;
  logic              ac_we_q, ac_we_d;
  logic              mem_req_q, mem_req_d;
  logic              err_q, err_d;
  logic              tmr_clear, tmr_enable, tmr_done_c;

  wb_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .done_c (tmr_done_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ac_q       <= '0;
      mdata_q    <= '0;
      maddr_q    <= '0;
      wr_ready_q <= 1'b1;
      ac_we_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ac_q       <= ac_d;
      mdata_q    <= mdata_d;
      maddr_q    <= maddr_d;
      wr_ready_q <= wr_ready_d;
      ac_we_q    <= ac_we_d;
      mem_req_q  <= mem_req_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    ac_d       = ac_q;
    mdata_d    = mdata_q;
    maddr_d    = maddr_q;
    err_d      = err_q;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.wr_valid && wr_ready_q) begin
          if (bus.choice == CHOICE_AC) begin
            state_d = AC_WR;
            ac_d    = bus.data_in;
          end else begin
            state_d   = MEM_REQ;
            maddr_d   = bus.addr_in;
            mdata_d   = bus.data_in;
            tmr_clear = 1'b1;
          end
        end
      end
      AC_WR: state_d = IDLE;
      MEM_REQ: begin
        // An acknowledge stops the count, so it beats a same-cycle timeout
        tmr_enable = !bus.mem_ack;
        if (bus.mem_ack) begin
          state_d = DONE;
        end else if (tmr_done_c) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state
    wr_ready_d = (state_d == IDLE);
    ac_we_d    = (state_d == AC_WR);
    mem_req_d  = (state_d == MEM_REQ);
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.ac_out   = ac_q;
  assign bus.ac_we    = ac_we_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = maddr_q;
  assign bus.mem_data = mdata_q;
  assign bus.err      = err_q;

endmodule

// File: doc/wb_route.md
WB_ROUTE -- requirements
Module: wb_route

Interface
REQ-001 Parameter DATA_W, default 8, width of the result, accumulator and memory data.
REQ-002 Parameter ADDR_W, default 8, width of the memory address.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles to wait for mem_ack before aborting a memory write.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port wr_valid, input, 1, a write-back request is presented this cycle.
REQ-007 Port wr_ready, output, 1, the block accepts a request this cycle.
REQ-008 Port data_in, input, DATA_W, result to write back.
REQ-009 Port addr_in, input, ADDR_W, memory address; used only for memory writes.
REQ-010 Port choice, input, 1, destination select: 1 = accumulator, 0 = memory (same encoding as the operand-source mux).
REQ-011 Port ac_out, output, DATA_W, registered accumulator value.
REQ-012 Port ac_we, output, 1, one-cycle pulse marking an accumulator update.
REQ-013 Port mem_req, output, 1, memory write request, level-held until acknowledged or timed out.
REQ-014 Port mem_addr, output, ADDR_W, registered memory write address.
REQ-015 Port mem_data, output, DATA_W, registered memory write data.
REQ-016 Port mem_ack, input, 1, memory completion strobe.
REQ-017 Port err, output, 1, sticky flag set on a memory write timeout.

Function
REQ-018 The FSM SHALL have the states IDLE, AC_WR, MEM_REQ and DONE.
REQ-019 wr_ready SHALL be 1 only in IDLE; a request is accepted when wr_valid and wr_ready are both 1.
REQ-020 On acceptance with choice=1, the FSM SHALL go to AC_WR and load data_in into ac_out on that edge.
REQ-021 In AC_WR, ac_we SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE, giving a 2-cycle accept-to-accept period.
REQ-022 On acceptance with choice=0, the block SHALL capture addr_in and data_in into mem_addr and mem_data, go to MEM_REQ and clear the wait counter.
REQ-023 In MEM_REQ, mem_req SHALL be 1 and mem_addr and mem_data SHALL stay stable.
REQ-024 While in MEM_REQ, mem_ack=1 SHALL move the FSM to DONE on the next edge.
REQ-025 A mem_ack that arrives in the first MEM_REQ cycle SHALL be honoured.
REQ-026 mem_ack outside MEM_REQ SHALL be ignored.
REQ-027 The wait counter SHALL increment on each MEM_REQ cycle without mem_ack.
REQ-028 When the counter reaches TIMEOUT without mem_ack, the block SHALL set err and go to DONE.
REQ-029 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the acknowledge SHALL win and err SHALL stay unchanged.
REQ-030 The wait counter SHALL be wide enough to hold TIMEOUT and SHALL saturate, never wrap.
REQ-031 DONE SHALL last one cycle with mem_req=0, then the FSM SHALL return to IDLE.
REQ-032 wr_valid, data_in, choice and addr_in SHALL be ignored outside IDLE.
REQ-033 A memory write SHALL never modify ac_out.
REQ-034 err SHALL stay set until reset.

Reset
REQ-035 When reset=1 on a rising edge, the block SHALL set: FSM to IDLE, ac_out=0, ac_we=0, mem_req=0, mem_addr=0, mem_data=0, counter=0, err=0.
REQ-036 Reset SHALL take priority over every other event, including mid-transaction in MEM_REQ (mem_req drops on the next edge) and in AC_WR (the ac_we pulse is cancelled).
REQ-037 wr_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-038 The state encoding and the choice encoding constants (CHOICE_AC=1, CHOICE_MEM=0) SHALL reside in a shared package, also used by the operand-source mux.
REQ-039 The wait counter SHALL be a sub-module named wb_timer, with clear, enable, saturating count and a done flag.

Verification
REQ-040 Accumulator write: reset, then wr_valid=1, choice=1, data_in=8'h5A -> ac_out=8'h5A after 1 edge, ac_we high for 1 cycle, mem_req stays 0.
REQ-041 Memory write: choice=0, data_in=8'hBC, addr_in=8'h10, mem_ack 3 cycles later -> mem_req high for 4 cycles with mem_addr=8'h10 and mem_data=8'hBC, ac_out unchanged, err=0.
REQ-042 Timeout: choice=0, mem_ack never asserted -> err=1 after TIMEOUT=15 MEM_REQ cycles, then DONE, then IDLE; err still 1 afterwards.
REQ-043 Ack at limit: mem_ack asserted exactly in the cycle the counter reaches TIMEOUT -> err=0 and a normal completion.
REQ-044 Back-to-back and ignored input: accumulator write 8'h5F then memory write -> the second request is accepted only when wr_ready=1; wr_valid pulsed during MEM_REQ -> no effect.
REQ-045 Reset mid-transaction: reset asserted in the second MEM_REQ cycle -> all outputs at their reset values on the next edge, wr_ready=1 after reset deasserts.
